bcd_conv_ctrl: RTL and testbench

BCD_CONV_CTRL -- requirements
Module: bcd_conv_ctrl

---
 rtl/bcd_pkg.sv | 20 ++
 rtl/bcd_dabble_step.sv | 31 +++
 rtl/bcd_conv_ctrl.sv | 125 ++++++++++++
 tb/tb_bcd_conv_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and sizing constants for the binary-to-BCD conversion controller.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } bcd_state_e;

   localparam int BCD_IN_W_DEF   = 12;
   localparam int BCD_DIGITS_DEF = 4;

   // Iteration counter must hold 0..IN_W-1; sized from the operand width.
   function automatic int bcd_cnt_w(input int in_w);
      return $clog2(in_w + 1);
   endfunction

   localparam int BCD_CNT_W = bcd_cnt_w(BCD_IN_W_DEF);

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift {digits,binary} left by one.
module bcd_dabble_step
   import bcd_pkg::*;
#(
   parameter int IN_W   = BCD_IN_W_DEF,
   parameter int DIGITS = BCD_DIGITS_DEF
) (
   input  logic [4*DIGITS-1:0] bcd,
   input  logic [IN_W-1:0]     bin,
   output logic [4*DIGITS-1:0] bcd_nxt,
   output logic [IN_W-1:0]     bin_nxt
);

   logic [4*DIGITS-1:0] adj;
   logic                unused_carry;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // The top digit's carry-out cannot be set when DIGITS covers the operand range.
   assign unused_carry = adj[4*DIGITS-1];
   assign bcd_nxt      = {adj[4*DIGITS-2:0], bin[IN_W-1]};
   assign bin_nxt      = {bin[IN_W-2:0], 1'b0};

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD converter (one double-dabble step per clock) with valid/ack handshake.
// Define BCD_BLANK_EN to build the leading-zero blanking flags; otherwise digit_blank is tied to 0.
//
// state    | meaning
// ST_IDLE  | ready=1, waiting for valid to capture mult_result
// ST_SHIFT | running IN_W dabble iterations on the working registers
// ST_DONE  | BCD_valid=1, result held until BCD_ack
module bcd_conv_ctrl
   import bcd_pkg::*;
#(
   parameter int IN_W   = BCD_IN_W_DEF,
   parameter int DIGITS = BCD_DIGITS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IN_W-1:0]     mult_result,
   input  logic                valid,
   output logic                ready,
   output logic [4*DIGITS-1:0] BCD_code,
   output logic                BCD_valid,
   input  logic                BCD_ack,
   output logic [DIGITS-1:0]   digit_blank
);

   localparam int                CNT_W     = bcd_cnt_w(IN_W);
   localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(IN_W - 1);
   localparam logic [63:0]       DEC_SPAN  = 64'(10) ** DIGITS;
   localparam logic [63:0]       BIN_MAX   = (64'(1) << IN_W) - 64'(1);

   if (DEC_SPAN <= BIN_MAX) begin : g_range_check
      $error("bcd_conv_ctrl: DIGITS too small to hold 2**IN_W-1");
   end

   bcd_state_e          state;
   logic [IN_W-1:0]     work_bin;
   logic [4*DIGITS-1:0] work_bcd;
   logic [CNT_W-1:0]    cnt;
   logic [IN_W-1:0]     bin_nxt;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic                load_res;

   bcd_dabble_step #(
      .IN_W   (IN_W),
      .DIGITS (DIGITS)
   ) u_step (
      .bcd     (work_bcd),
      .bin     (work_bin),
      .bcd_nxt (bcd_nxt),
      .bin_nxt (bin_nxt)
   );

   // The edge that completes the last iteration publishes the step output directly.
   assign load_res = (state == ST_SHIFT) && (cnt == LAST_ITER);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ready     <= 1'b1;
         BCD_valid <= 1'b0;
         BCD_code  <= '0;
         work_bin  <= '0;
         work_bcd  <= '0;
         cnt       <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (valid) begin
                  work_bin <= mult_result;
                  work_bcd <= '0;
                  cnt      <= '0;
                  ready    <= 1'b0;
                  state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               work_bin <= bin_nxt;
               work_bcd <= bcd_nxt;
               cnt      <= cnt + 1'b1;
               if (load_res) begin
                  BCD_code  <= bcd_nxt;
                  BCD_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (BCD_ack) begin
                  BCD_valid <= 1'b0;
                  ready     <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;
   logic              zero_above;

   // Digit 0 is never blanked so a zero result still shows one digit.
   always_comb begin
      blank_nxt  = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above   = zero_above && (bcd_nxt[4*i +: 4] == 4'd0);
         blank_nxt[i] = zero_above;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_blank <= '0;
      end else if (load_res) begin
         digit_blank <= blank_nxt;
      end
   end
`else
   assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Directed and random checks of bcd_conv_ctrl against a decimal-arithmetic reference model.
module tb_bcd_conv_ctrl;

   localparam int IN_W   = 12;
   localparam int DIGITS = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [IN_W-1:0]     mult_result = '0;
   logic                valid = 1'b0;
   logic                BCD_ack = 1'b0;
   logic                ready;
   logic                BCD_valid;
   logic [4*DIGITS-1:0] BCD_code;
   logic [DIGITS-1:0]   digit_blank;

   int                  n_checks = 0;
   int                  n_fail = 0;
   logic [15:0]         last_code = 16'h0;
   logic [3:0]          last_blank = 4'h0;

   always #5 clk = ~clk;

   bcd_conv_ctrl #(
      .IN_W   (IN_W),
      .DIGITS (DIGITS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mult_result (mult_result),
      .valid       (valid),
      .ready       (ready),
      .BCD_code    (BCD_code),
      .BCD_valid   (BCD_valid),
      .BCD_ack     (BCD_ack),
      .digit_blank (digit_blank)
   );

   function automatic logic [15:0] model_bcd(input int n);
      logic [15:0] r;
      int          p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((n / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [3:0] model_blank(input int n);
      logic [3:0] r;
      int         p;
      r = '0;
`ifdef BCD_BLANK_EN
      p = 10;
      for (int i = 1; i < DIGITS; i++) begin
         r[i] = (n < p);
         p = p * 10;
      end
`else
      p = 0;
      r[0] = (p != 0);
`endif
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input int n);
      mult_result = IN_W'(n);
      valid = 1'b1;
      check("ready_idle", 32'(ready), 32'd1);
      step();
      valid = 1'b0;
      check("ready_busy", 32'(ready), 32'd0);
   endtask

   task automatic wait_done(input int n);
      int cyc;
      cyc = 0;
      while (!BCD_valid && cyc < 40) begin
         check("code_hold", 32'(BCD_code), 32'(last_code));
         check("blank_hold", 32'(digit_blank), 32'(last_blank));
         step();
         cyc++;
      end
      check("latency", 32'(cyc), 32'd12);
      check("code", 32'(BCD_code), 32'(model_bcd(n)));
      check("blank", 32'(digit_blank), 32'(model_blank(n)));
      check("ready_done", 32'(ready), 32'd0);
      last_code  = model_bcd(n);
      last_blank = model_blank(n);
   endtask

   task automatic release_result(input int ack_delay);
      for (int k = 0; k < ack_delay; k++) begin
         step();
         check("valid_hold", 32'(BCD_valid), 32'd1);
      end
      BCD_ack = 1'b1;
      step();
      BCD_ack = 1'b0;
      check("ready_after_ack", 32'(ready), 32'd1);
      check("valid_after_ack", 32'(BCD_valid), 32'd0);
      check("code_after_ack", 32'(BCD_code), 32'(last_code));
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_valid", 32'(BCD_valid), 32'd0);
      check("rst_code", 32'(BCD_code), 32'd0);
      check("rst_blank", 32'(digit_blank), 32'd0);
      rst_n = 1'b1;
      step();

      // stray ack while idle must do nothing
      BCD_ack = 1'b1;
      step();
      BCD_ack = 1'b0;
      check("ack_idle_ready", 32'(ready), 32'd1);
      check("ack_idle_valid", 32'(BCD_valid), 32'd0);

      // maximum operand, ack two cycles late
      accept(4095);
      wait_done(4095);
      release_result(2);

      // zero operand
      accept(0);
      wait_done(0);
      release_result(0);

      // valid during SHIFT and DONE is ignored, never queued
      accept(1234);
      mult_result = IN_W'(999);
      valid = 1'b1;
      wait_done(1234);
      valid = 1'b0;
      release_result(1);
      for (int k = 0; k < 3; k++) begin
         step();
         check("no_queue_ready", 32'(ready), 32'd1);
         check("no_queue_valid", 32'(BCD_valid), 32'd0);
      end

      // indefinite hold without ack
      accept(58);
      wait_done(58);
      for (int k = 0; k < 50; k++) begin
         step();
         check("hold_valid", 32'(BCD_valid), 32'd1);
         check("hold_code", 32'(BCD_code), 32'h0058);
         check("hold_ready", 32'(ready), 32'd0);
      end
      release_result(0);

      // reset in the middle of SHIFT aborts the conversion
      accept(777);
      repeat (6) step();
      rst_n = 1'b0;
      #1;
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_valid", 32'(BCD_valid), 32'd0);
      check("abort_code", 32'(BCD_code), 32'd0);
      check("abort_blank", 32'(digit_blank), 32'd0);
      step();
      rst_n = 1'b1;
      last_code  = 16'h0;
      last_blank = 4'h0;
      accept(321);
      wait_done(321);
      release_result(0);

      // back-to-back: valid and ack coincide in DONE
      accept(100);
      wait_done(100);
      mult_result = IN_W'(4000);
      valid = 1'b1;
      BCD_ack = 1'b1;
      step();
      BCD_ack = 1'b0;
      check("b2b_ready", 32'(ready), 32'd1);
      check("b2b_valid", 32'(BCD_valid), 32'd0);
      check("b2b_code", 32'(BCD_code), 32'h0100);
      step();
      valid = 1'b0;
      check("b2b_accept", 32'(ready), 32'd0);
      wait_done(4000);
      release_result(1);

      // random operands and ack delays
      for (int r = 0; r < 20; r++) begin
         int n;
         n = int'($urandom_range(0, 4095));
         accept(n);
         wait_done(n);
         release_result(int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
